rf_mp: RTL and testbench

//  Parametrised multi-port integer register file for the pipelined core; successor to the single-cycle RF.
//  NRP combinational read ports, NWP synchronous write ports, register 0 hardwired to zero.

---
 rtl/rf_pkg.sv | 11 +
 rtl/rf_rd_port.sv | 51 +++++
 rtl/rf_mp.sv | 88 ++++++++
 tb/tb_rf_mp.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared defaults and types for the multi-port integer register file.
package rf_pkg;

  localparam int RF_DW   = 32;
  localparam int RF_NREG = 32;
  localparam int RF_AW   = $clog2(RF_NREG);

  typedef logic [RF_AW-1:0] rf_addr_t;
  typedef logic [RF_DW-1:0] rf_data_t;

endpackage

// File: rtl/rf_rd_port.sv
// One combinational read port: x0 forcing, same-cycle write bypass and busy lookup.
module rf_rd_port
  import rf_pkg::*;
#(
  parameter int DW     = RF_DW,
  parameter int AW     = RF_AW,
  parameter int NWP    = 2,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]     rd_addr_i,
  input  logic [DW-1:0]     arr_data_i,
  input  logic              arr_busy_i,
  input  logic [NWP-1:0]    wr_en_i,
  input  logic [NWP*AW-1:0] wr_addr_i,
  input  logic [NWP*DW-1:0] wr_data_i,
  output logic [DW-1:0]     rd_data_o,
  output logic              rd_busy_o
);

  logic          bypass_en;
  logic          hit;
  logic [DW-1:0] hit_data;

  assign bypass_en = (BYPASS != 0);

  // Ascending scan so the highest-indexed matching write port wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int p = 0; p < NWP; p++) begin
      if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] == rd_addr_i)) begin
        hit      = 1'b1;
        hit_data = wr_data_i[p*DW +: DW];
      end
    end
  end

  always_comb begin
    rd_data_o = arr_data_i;
    rd_busy_o = arr_busy_i;
    if (bypass_en && hit) begin
      rd_data_o = hit_data;
      rd_busy_o = 1'b0;
    end
    if (rd_addr_i == '0) begin
      rd_data_o = '0;
      rd_busy_o = 1'b0;
    end
  end

endmodule

// File: rtl/rf_mp.sv
// Multi-port register file with x0 hardwired to zero and a busy-bit scoreboard.
module rf_mp
  import rf_pkg::*;
#(
  parameter int DW     = RF_DW,
  parameter int NREG   = RF_NREG,
  parameter int AW     = $clog2(NREG),
  parameter int NRP    = 2,
  parameter int NWP    = 2,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NWP-1:0]    wr_en,
  input  logic [NWP*AW-1:0] wr_addr,
  input  logic [NWP*DW-1:0] wr_data,
  input  logic [NRP*AW-1:0] rd_addr,
  output logic [NRP*DW-1:0] rd_data,
  output logic [NRP-1:0]    rd_busy,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_addr,
  input  logic              flush
);

  logic [NREG-1:0][DW-1:0] mem_q, mem_d;
  logic [NREG-1:0]         busy_q, busy_d;

  // Later ports overwrite earlier ones, resolving same-address conflicts.
  always_comb begin
    mem_d = mem_q;
    for (int p = 0; p < NWP; p++) begin
      if (wr_en[p] && (wr_addr[p*AW +: AW] != '0)) begin
        mem_d[wr_addr[p*AW +: AW]] = wr_data[p*DW +: DW];
      end
    end
    mem_d[0] = '0;
  end

  // Priority: flush > alloc > write-clear, hence alloc applied after clears.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int p = 0; p < NWP; p++) begin
        if (wr_en[p]) begin
          busy_d[wr_addr[p*AW +: AW]] = 1'b0;
        end
      end
      if (alloc_en) begin
        busy_d[alloc_addr] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  for (genvar r = 0; r < NRP; r++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rd_addr[r*AW +: AW];

    rf_rd_port #(
      .DW    (DW),
      .AW    (AW),
      .NWP   (NWP),
      .BYPASS(BYPASS)
    ) u_rd_port (
      .rd_addr_i (addr),
      .arr_data_i(mem_q[addr]),
      .arr_busy_i(busy_q[addr]),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_data_o (rd_data[r*DW +: DW]),
      .rd_busy_o (rd_busy[r])
    );
  end

endmodule

// File: tb/tb_rf_mp.sv
// Directed bench for rf_mp: one bypassing and one non-bypassing instance on shared inputs.
module tb_rf_mp;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic [1:0]    wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*DW-1:0] wr_data;
  logic [2*AW-1:0] rd_addr;
  logic          alloc_en;
  logic [AW-1:0] alloc_addr;
  logic          flush;

  logic [2*DW-1:0] rd_data_b, rd_data_n;
  logic [1:0]      rd_busy_b, rd_busy_n;

  int n_tests = 0;
  int n_fail  = 0;

  rf_mp #(.DW(DW), .NREG(32), .NRP(2), .NWP(2), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush)
  );

  rf_mp #(.DW(DW), .NREG(32), .NRP(2), .NWP(2), .BYPASS(0)) u_nob (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] db(input int p);
    return rd_data_b[p*DW +: DW];
  endfunction

  function automatic logic [31:0] dn(input int p);
    return rd_data_n[p*DW +: DW];
  endfunction

  // Drivers
  task automatic clr();
    wr_en      = '0;
    wr_addr    = '0;
    wr_data    = '0;
    alloc_en   = 1'b0;
    alloc_addr = '0;
    flush      = 1'b0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d);
    wr_en[p]              = 1'b1;
    wr_addr[p*AW +: AW]   = a;
    wr_data[p*DW +: DW]   = d;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic alloc(input logic [AW-1:0] a);
    alloc_en   = 1'b1;
    alloc_addr = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
    #1;
  endtask

  initial begin
    clr();
    rd_addr = '0;
    rst_n   = 1'b0;
    rd(0, 5'd5);
    rd(1, 5'd9);
    #2;
    check("reset_data_b", db(0), 32'h0);
    check("reset_busy_b", {30'd0, rd_busy_b}, 32'h0);
    check("reset_busy_n", {30'd0, rd_busy_n}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // x0: writes on both ports and alloc are all dropped
    wr(0, 5'd0, 32'hFFFF_FFFF);
    wr(1, 5'd0, 32'hFFFF_FFFF);
    alloc(5'd0);
    rd(0, 5'd0);
    #1;
    check("x0_bypass_data", db(0), 32'h0);
    check("x0_bypass_busy", {31'd0, rd_busy_b[0]}, 32'h0);
    step();
    check("x0_after_b", db(0), 32'h0);
    check("x0_after_n", dn(0), 32'h0);
    check("x0_busy_after", {30'd0, rd_busy_b}, 32'h0);

    // Write-write conflict: port1 wins
    wr(0, 5'd7, 32'h1111);
    wr(1, 5'd7, 32'h2222);
    rd(0, 5'd7);
    #1;
    check("conflict_bypass", db(0), 32'h2222);
    check("conflict_nob_old", dn(0), 32'h0);
    step();
    check("conflict_arr_b", db(0), 32'h2222);
    check("conflict_arr_n", dn(0), 32'h2222);

    // Bypass vs array-only timing
    wr(0, 5'd3, 32'hABCD);
    rd(1, 5'd3);
    #1;
    check("bypass_same_b", db(1), 32'hABCD);
    check("bypass_same_n", dn(1), 32'h0);
    step();
    check("bypass_next_n", dn(1), 32'hABCD);

    // Scoreboard: alloc, write-clear, alloc+write same edge
    rd(0, 5'd9);
    alloc(5'd9);
    #1;
    check("sb_busy_pre", {31'd0, rd_busy_b[0]}, 32'h0);
    step();
    check("sb_alloc_b", {31'd0, rd_busy_b[0]}, 32'h1);
    check("sb_alloc_n", {31'd0, rd_busy_n[0]}, 32'h1);
    wr(1, 5'd9, 32'h99);
    #1;
    check("sb_wr_same_b", {31'd0, rd_busy_b[0]}, 32'h0);
    check("sb_wr_same_n", {31'd0, rd_busy_n[0]}, 32'h1);
    check("sb_wr_data_b", db(0), 32'h99);
    step();
    check("sb_clr_b", {31'd0, rd_busy_b[0]}, 32'h0);
    check("sb_clr_n", {31'd0, rd_busy_n[0]}, 32'h0);
    alloc(5'd9);
    wr(0, 5'd9, 32'h55);
    step();
    check("sb_alloc_wins_b", {31'd0, rd_busy_b[0]}, 32'h1);
    check("sb_alloc_wins_n", {31'd0, rd_busy_n[0]}, 32'h1);
    check("sb_alloc_data_n", dn(0), 32'h55);

    // Flush beats same-edge alloc; same-edge write still commits
    alloc(5'd4); step();
    alloc(5'd5); step();
    alloc(5'd6); step();
    rd(0, 5'd4);
    rd(1, 5'd6);
    #1;
    check("flush_pre_x4", {31'd0, rd_busy_b[0]}, 32'h1);
    check("flush_pre_x6", {31'd0, rd_busy_n[1]}, 32'h1);
    flush = 1'b1;
    alloc(5'd8);
    wr(0, 5'd10, 32'h1010);
    step();
    check("flush_x4", {31'd0, rd_busy_b[0]}, 32'h0);
    check("flush_x6", {31'd0, rd_busy_n[1]}, 32'h0);
    rd(0, 5'd8);
    rd(1, 5'd10);
    #1;
    check("flush_x8_b", {31'd0, rd_busy_b[0]}, 32'h0);
    check("flush_x8_n", {31'd0, rd_busy_n[0]}, 32'h0);
    check("flush_wr_commit", dn(1), 32'h1010);
    rd(0, 5'd5);
    rd(1, 5'd9);
    #1;
    check("flush_x5", {31'd0, rd_busy_b[0]}, 32'h0);
    check("flush_x9", {31'd0, rd_busy_n[1]}, 32'h0);

    // Asynchronous reset mid-stream
    wr(0, 5'd5, 32'hDEAD);
    step();
    alloc(5'd5);
    step();
    check("pre_rst_data", dn(0), 32'hDEAD);
    check("pre_rst_busy", {31'd0, rd_busy_n[0]}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_data_b", db(0), 32'h0);
    check("rst_data_n", dn(0), 32'h0);
    check("rst_busy_b", {30'd0, rd_busy_b}, 32'h0);
    check("rst_busy_n", {30'd0, rd_busy_n}, 32'h0);
    check("rst_x9", dn(1), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
